instr_cache_fill_unit: RTL and testbench

- Refill engine downstream of instr_cache_ctlr.
- On an instruction-fetch miss that the controller permits, issues one line request to the instruction memory port and collects WORDS_PER_LINE return beats into a line buffer.
- Presents the completed line and its line-aligned address to the instruction cache for a one-cycle replacement write.
- Drives the fetch stall while a refill is pending.

---
 rtl/instr_cache_fill_unit_pkg.sv | 18 +
 rtl/instr_cache_fill_unit.sv | 136 +++++++++++++
 tb/tb_instr_cache_fill_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_cache_fill_unit_pkg.sv
// Shared definitions for the instruction-cache refill path.
// Holds the refill FSM state encoding and the line-offset width helper, so
// the cache sets and the fill unit agree on how a byte address splits into line/offset.
package instr_cache_fill_unit_pkg;

  typedef enum logic [1:0] {
    FILL_IDLE    = 2'd0,
    FILL_REQ     = 2'd1,
    FILL_COLLECT = 2'd2,
    FILL_DONE    = 2'd3
  } fill_state_e;

  // Number of byte-offset bits inside one cache line.
  function automatic int fill_offset_bits(input int words_per_line, input int data_width);
    return $clog2(words_per_line * data_width / 8);
  endfunction

endpackage

// File: rtl/instr_cache_fill_unit.sv
// Instruction-cache refill engine: on a permitted fetch miss, requests one line
// from instruction memory, gathers WORDS_PER_LINE beats, and presents the line
// for a single-cycle cache write while holding the fetch stage stalled.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   pc_f_i, instr_hit_f_i          fetch PC and hit/miss from the cache controller
//   ic_repl_permit_i               controller allows a replacement
//   mem_req_valid_o/ready_i/addr_o line request handshake to instruction memory
//   mem_rvalid_i, mem_rdata_i      return beats, address order, gaps allowed
//   fill_valid_o/addr_o/line_o     one-cycle cache write of the completed line
//   stall_f_o, busy_o              fetch stall and refill-in-progress status
// Latency: miss-to-fill minimum = 1 + 1 + WORDS_PER_LINE + 1 cycles.
module instr_cache_fill_unit
  import instr_cache_fill_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [ADDR_WIDTH-1:0]              pc_f_i,
  input  logic                               instr_hit_f_i,
  input  logic                               ic_repl_permit_i,
  output logic                               mem_req_valid_o,
  input  logic                               mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]              mem_req_addr_o,
  input  logic                               mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]              mem_rdata_i,
  output logic                               fill_valid_o,
  output logic [ADDR_WIDTH-1:0]              fill_addr_o,
  output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] fill_line_o,
  output logic                               stall_f_o,
  output logic                               busy_o
);

  localparam int OFFSET_BITS = fill_offset_bits(WORDS_PER_LINE, DATA_WIDTH);
  localparam int CNT_W       = $clog2(WORDS_PER_LINE);
  localparam int LINE_W      = WORDS_PER_LINE * DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_LINE - 1);

  fill_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0]   buf_q [WORDS_PER_LINE];
  logic [DATA_WIDTH-1:0]   buf_d [WORDS_PER_LINE];
  logic [ADDR_WIDTH-1:0]   fill_addr_q, fill_addr_d;
  logic [LINE_W-1:0]       fill_line_q, fill_line_d;

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_cnt_d  = beat_cnt_q;
    buf_d       = buf_q;
    fill_addr_d = fill_addr_q;
    fill_line_d = fill_line_q;

    case (state_q)
      FILL_IDLE: begin
        if (!instr_hit_f_i && ic_repl_permit_i) begin
          addr_d     = pc_f_i & LINE_MASK;
          beat_cnt_d = '0;
          state_d    = FILL_REQ;
        end
      end

      FILL_REQ: begin
        // Request stays up with a frozen address until accepted; no abort path.
        if (mem_req_ready_i) begin
          state_d = FILL_COLLECT;
        end
      end

      FILL_COLLECT: begin
        if (mem_rvalid_i) begin
          buf_d[beat_cnt_q] = mem_rdata_i;
          beat_cnt_d        = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            state_d     = FILL_DONE;
            // Output registers capture the line including the beat arriving now,
            // so the cache sees a complete line in the DONE cycle and the values
            // persist after the buffer starts refilling for the next miss.
            fill_addr_d = addr_q;
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
              fill_line_d[k*DATA_WIDTH +: DATA_WIDTH] = buf_d[k];
            end
          end
        end
      end

      FILL_DONE: begin
        state_d = FILL_IDLE;
      end

      default: begin
        state_d = FILL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= FILL_IDLE;
      addr_q      <= '0;
      beat_cnt_q  <= '0;
      fill_addr_q <= '0;
      fill_line_q <= '0;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beat_cnt_q  <= beat_cnt_d;
      fill_addr_q <= fill_addr_d;
      fill_line_q <= fill_line_d;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  assign mem_req_valid_o = (state_q == FILL_REQ);
  assign mem_req_addr_o  = addr_q;
  assign fill_valid_o    = (state_q == FILL_DONE);
  assign fill_addr_o     = fill_addr_q;
  assign fill_line_o     = fill_line_q;
  assign busy_o          = (state_q != FILL_IDLE);
  // In IDLE the stall tracks the live hit so a miss stalls in the same cycle.
  assign stall_f_o       = (state_q == FILL_IDLE) ? ~instr_hit_f_i : 1'b1;

endmodule

// File: tb/tb_instr_cache_fill_unit.sv
// Self-checking bench for instr_cache_fill_unit (default parameters).
// Per-cycle table rows check control outputs; a scoreboard checks request
// addresses and filled lines against a model built from the driven stimulus.
module tb_instr_cache_fill_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WPL = 4;
  localparam logic [31:0] LMASK = 32'hFFFF_FFF0;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [AW-1:0]  pc_f_i;
  logic           instr_hit_f_i;
  logic           ic_repl_permit_i;
  logic           mem_req_valid_o;
  logic           mem_req_ready_i;
  logic [AW-1:0]  mem_req_addr_o;
  logic           mem_rvalid_i;
  logic [DW-1:0]  mem_rdata_i;
  logic           fill_valid_o;
  logic [AW-1:0]  fill_addr_o;
  logic [WPL*DW-1:0] fill_line_o;
  logic           stall_f_o;
  logic           busy_o;

  instr_cache_fill_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .pc_f_i           (pc_f_i),
    .instr_hit_f_i    (instr_hit_f_i),
    .ic_repl_permit_i (ic_repl_permit_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
    .fill_valid_o     (fill_valid_o),
    .fill_addr_o      (fill_addr_o),
    .fill_line_o      (fill_line_o),
    .stall_f_o        (stall_f_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic rst, hit, permit, ready, rvalid;
    logic [31:0] rdata;
    logic miss;   // this row starts a refill in the model
    logic beat;   // this row's rdata is a beat the DUT must capture
    logic e_stall, e_req, e_busy, e_fill;
  } vec_t;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] line;
  } fill_t;

  int checks = 0;
  int errors = 0;

  vec_t        tbl[$];
  logic [31:0] exp_req_q[$];
  fill_t       exp_fill_q[$];
  logic [127:0] model_line;
  logic [31:0]  model_addr;
  int           model_beats;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t v(input logic [31:0] pc, input logic rst, hit, permit, ready, rvalid,
                             input logic [31:0] rdata, input logic miss, beat,
                             input logic e_stall, e_req, e_busy, e_fill);
    vec_t r;
    r.pc = pc; r.rst = rst; r.hit = hit; r.permit = permit; r.ready = ready;
    r.rvalid = rvalid; r.rdata = rdata; r.miss = miss; r.beat = beat;
    r.e_stall = e_stall; r.e_req = e_req; r.e_busy = e_busy; r.e_fill = e_fill;
    return r;
  endfunction

  // Drive one row after the clock edge, update the model, check at negedge.
  task automatic apply(input vec_t r, input string tag);
    @(posedge clk); #1;
    reset_i          = r.rst;
    pc_f_i           = r.pc;
    instr_hit_f_i    = r.hit;
    ic_repl_permit_i = r.permit;
    mem_req_ready_i  = r.ready;
    mem_rvalid_i     = r.rvalid;
    mem_rdata_i      = r.rdata;
    if (r.miss) begin
      model_addr  = r.pc & LMASK;
      model_beats = 0;
      model_line  = '0;
      exp_req_q.push_back(model_addr);
    end
    if (r.beat) begin
      model_line[model_beats*32 +: 32] = r.rdata;
      model_beats++;
      if (model_beats == WPL) begin
        exp_fill_q.push_back('{addr: model_addr, line: model_line});
        model_beats = 0;
      end
    end
    @(negedge clk);
    chk({tag, " stall"}, 128'(stall_f_o), 128'(r.e_stall));
    chk({tag, " req_vld"}, 128'(mem_req_valid_o), 128'(r.e_req));
    chk({tag, " busy"}, 128'(busy_o), 128'(r.e_busy));
    chk({tag, " fill_vld"}, 128'(fill_valid_o), 128'(r.e_fill));
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("%s[%0d]", name, i));
    end
    tbl.delete();
  endtask

  // Scoreboard monitor: request address held while waiting, fills match model.
  always @(negedge clk) begin
    if (reset_i === 1'b0) begin
      if (mem_req_valid_o) begin
        if (exp_req_q.size() == 0) begin
          chk("unexpected_req", 128'(mem_req_addr_o), 128'hX);
        end else begin
          chk("req_addr", 128'(mem_req_addr_o), 128'(exp_req_q[0]));
          if (mem_req_ready_i) void'(exp_req_q.pop_front());
        end
      end
      if (fill_valid_o) begin
        if (exp_fill_q.size() == 0) begin
          chk("unexpected_fill", 128'(fill_addr_o), 128'hX);
        end else begin
          chk("fill_addr", 128'(fill_addr_o), 128'(exp_fill_q[0].addr));
          chk("fill_line", fill_line_o, exp_fill_q[0].line);
          void'(exp_fill_q.pop_front());
        end
      end
    end
  end

  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  initial begin
    reset_i = 1'b1; pc_f_i = '0; instr_hit_f_i = 1'b1; ic_repl_permit_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    model_line = '0; model_addr = '0; model_beats = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 128'(busy_o), 128'd0);
    chk("rst req_vld", 128'(mem_req_valid_o), 128'd0);
    chk("rst req_addr", 128'(mem_req_addr_o), 128'd0);
    chk("rst fill_vld", 128'(fill_valid_o), 128'd0);
    chk("rst fill_addr", 128'(fill_addr_o), 128'd0);
    chk("rst fill_line", fill_line_o, 128'd0);
    chk("rst stall_hit", 128'(stall_f_o), 128'd0);
    instr_hit_f_i = 1'b0; #1;
    chk("rst stall_miss", 128'(stall_f_o), 128'd1);

    // Basic refill, back-to-back beats, then a hit after the fill.
    tbl.push_back(v(32'h0000_1234, 0, 0, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    tbl.push_back(v(32'h0000_1234, 0, 0, 1, 1, 0, 32'h0,         0, 0, 1, 1, 1, 0));
    tbl.push_back(v(32'h0000_1234, 0, 0, 1, 1, 1, 32'h1111_1111, 0, 1, 1, 0, 1, 0));
    tbl.push_back(v(32'h0000_1234, 0, 0, 1, 1, 1, 32'h2222_2222, 0, 1, 1, 0, 1, 0));
    tbl.push_back(v(32'h0000_1234, 0, 0, 1, 1, 1, 32'h3333_3333, 0, 1, 1, 0, 1, 0));
    tbl.push_back(v(32'h0000_1234, 0, 0, 1, 1, 1, 32'h4444_4444, 0, 1, 1, 0, 1, 0));
    tbl.push_back(v(32'h0000_1234, 0, 1, 1, 1, 0, 32'h0,         0, 0, 1, 0, 1, 1));
    tbl.push_back(v(32'h0000_1234, 0, 1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h0000_1234, 0, 1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0));
    run_table("basic");
    chk("basic hold_line", fill_line_o, 128'h44444444_33333333_22222222_11111111);
    chk("basic hold_addr", 128'(fill_addr_o), 128'h0000_1230);

    // Permit low with spurious beats, backpressure, gapped beats, ignored hit/permit.
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(32'h0000_2008, 0, 0, 0, 0, 1, DB, 0, 0, 1, 0, 0, 0));
    tbl.push_back(v(32'h0000_2008, 0, 0, 1, 0, 1, DB, 1, 0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(32'h0000_2008, 0, 0, 1, 0, 1, DB, 0, 0, 1, 1, 1, 0));
    tbl.push_back(v(32'h0000_2008, 0, 0, 1, 1, 1, DB, 0, 0, 1, 1, 1, 0));
    begin
      logic [6:0] pat;
      pat = 7'b1011001; // bit i = rvalid in collect cycle i: 1,0,0,1,1,0,1
      for (int i = 0; i < 7; i++) begin
        logic [31:0] d;
        d = pat[i] ? (32'hA000_0000 + 32'(i)) : DB;
        tbl.push_back(v(32'h0000_2008, 0, i[0], i[1], 0, pat[i], d, 0, pat[i], 1, 0, 1, 0));
      end
    end
    tbl.push_back(v(32'h0000_2008, 0, 1, 0, 0, 1, DB, 0, 0, 1, 0, 1, 1));
    tbl.push_back(v(32'h0000_2008, 0, 1, 0, 0, 1, DB, 0, 0, 0, 0, 0, 0));
    run_table("gaps");

    // Reset after two collected beats discards the refill.
    tbl.push_back(v(32'h0000_3014, 0, 0, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0, 0));
    tbl.push_back(v(32'h0000_3014, 0, 0, 1, 1, 0, 32'h0,         0, 0, 1, 1, 1, 0));
    tbl.push_back(v(32'h0000_3014, 0, 0, 1, 1, 1, 32'h5555_5555, 0, 1, 1, 0, 1, 0));
    tbl.push_back(v(32'h0000_3014, 0, 0, 1, 1, 1, 32'h6666_6666, 0, 1, 1, 0, 1, 0));
    tbl.push_back(v(32'h0000_3014, 1, 1, 0, 1, 1, 32'h7777_7777, 0, 0, 1, 0, 1, 0));
    run_table("rstmid");
    model_beats = 0;
    apply(v(32'h0000_3014, 0, 1, 0, 1, 1, 32'h8888_8888, 0, 0, 0, 0, 0, 0), "rstmid_after");
    chk("rstmid fill_line", fill_line_o, 128'd0);
    chk("rstmid fill_addr", 128'(fill_addr_o), 128'd0);
    for (int i = 0; i < 6; i++)
      tbl.push_back(v(32'h0000_3014, 0, 1, 1, 1, 1, 32'h9999_9999, 0, 0, 0, 0, 0, 0));
    run_table("rstmid_idle");

    chk("req_queue_drained", 128'(exp_req_q.size()), 128'd0);
    chk("fill_queue_drained", 128'(exp_fill_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
